// File: rtl/freepdk45_sram_1w1r_fifo_ctrl_pkg.sv
// Shared sizing and pointer helpers for the 1w1r SRAM FIFO controller.
// DEPTH is not a power of two, so pointer wrap is explicit.
package freepdk45_sram_pkg;

    localparam int DEPTH      = 120;
    localparam int ADDR_WIDTH = 7;
    localparam int DATA_WIDTH = 16;
    localparam int LVL_WIDTH  = $clog2(DEPTH + 3);
    localparam int CNT_WIDTH  = $clog2(DEPTH + 1);

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    function automatic addr_t ptr_inc(input addr_t ptr);
        if (ptr == ADDR_WIDTH'(DEPTH - 1)) begin
            ptr_inc = ADDR_WIDTH'(0);
        end else begin
            ptr_inc = ptr + ADDR_WIDTH'(1);
        end
    endfunction

endpackage

// File: rtl/freepdk45_sram_1w1r_fifo_ctrl_if.sv
// Client-side streaming bundle: push and pop handshakes plus the fill level.
interface freepdk45_sram_1w1r_fifo_ctrl_if;
    import freepdk45_sram_pkg::*;

    logic                 push_valid;
    logic                 push_ready;
    word_t                push_data;
    logic                 pop_valid;
    logic                 pop_ready;
    word_t                pop_data;
    logic [LVL_WIDTH-1:0] level;

    modport master (
        output push_valid, push_data, pop_ready,
        input  push_ready, pop_valid, pop_data, level
    );

    modport slave (
        input  push_valid, push_data, pop_ready,
        output push_ready, pop_valid, pop_data, level
    );

endinterface

// File: rtl/freepdk45_sram_1w1r_fifo_ctrl_outbuf.sv
// Two-entry register FIFO that holds words read back from the macro.
// Capture and pop may coincide; the head register is the visible output.
module sram_fifo_outbuf
    import freepdk45_sram_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       capture,
    input  word_t      cap_data,
    input  logic       pop,
    output word_t      head,
    output logic [1:0] cnt
);

    word_t      head_r;
    word_t      tail_r;
    logic [1:0] cnt_r;
    logic       pop_ok_s;

    assign pop_ok_s = pop && (cnt_r != 2'd0);
    assign head     = head_r;
    assign cnt      = cnt_r;

    // Entry and count update; the issue rule upstream keeps capture away from a full buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r <= DATA_WIDTH'(0);
            tail_r <= DATA_WIDTH'(0);
            cnt_r  <= 2'd0;
        end else begin
            case ({capture, pop_ok_s})
                2'b10: begin
                    if (cnt_r == 2'd0) begin
                        head_r <= cap_data;
                        cnt_r  <= 2'd1;
                    end else if (cnt_r == 2'd1) begin
                        tail_r <= cap_data;
                        cnt_r  <= 2'd2;
                    end else begin
                        cnt_r  <= cnt_r;
                    end
                end
                2'b01: begin
                    if (cnt_r == 2'd2) begin
                        head_r <= tail_r;
                        cnt_r  <= 2'd1;
                    end else begin
                        cnt_r  <= 2'd0;
                    end
                end
                2'b11: begin
                    if (cnt_r == 2'd2) begin
                        head_r <= tail_r;
                        tail_r <= cap_data;
                    end else begin
                        head_r <= cap_data;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/freepdk45_sram_1w1r_fifo_ctrl.sv
// FIFO controller wrapping the OpenRAM 120x16 1w1r macro: owns pointers, occupancy,
// read issue and the one-cycle read return path into a small output buffer.
module freepdk45_sram_1w1r_fifo_ctrl
    import freepdk45_sram_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    freepdk45_sram_1w1r_fifo_ctrl_if.slave bus,
    output logic                         sram_clk0,
    output logic                         sram_clk1,
    output logic                         sram_csb0,
    output addr_t                        sram_addr0,
    output word_t                        sram_din0,
    output logic                         sram_csb1,
    output addr_t                        sram_addr1,
    input  word_t                        sram_dout1
);

    addr_t                wr_ptr_r;
    addr_t                rd_ptr_r;
    logic [CNT_WIDTH-1:0] mem_cnt_r;
    logic                 inflight_r;
    logic [1:0]           ob_cnt_s;
    word_t                ob_head_s;
    logic                 push_ready_s;
    logic                 push_fire_s;
    logic                 issue_s;

    // Both decisions depend only on registered counts, never on pop_ready.
    assign push_ready_s = (mem_cnt_r < CNT_WIDTH'(DEPTH));
    assign push_fire_s  = bus.push_valid && push_ready_s;
    assign issue_s      = (mem_cnt_r != CNT_WIDTH'(0)) &&
                          (({1'b0, ob_cnt_s} + {2'b00, inflight_r}) < 3'd2);

    assign sram_clk0  = clk;
    assign sram_clk1  = clk;
    assign sram_csb0  = ~push_fire_s;
    assign sram_addr0 = wr_ptr_r;
    assign sram_din0  = bus.push_data;
    assign sram_csb1  = ~issue_s;
    assign sram_addr1 = rd_ptr_r;

    assign bus.push_ready = push_ready_s;
    assign bus.pop_valid  = (ob_cnt_s != 2'd0);
    assign bus.pop_data   = ob_head_s;
    assign bus.level      = LVL_WIDTH'(mem_cnt_r) + LVL_WIDTH'(inflight_r) + LVL_WIDTH'(ob_cnt_s);

    // Pointers, stored-word count and the read-return tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= ADDR_WIDTH'(0);
            rd_ptr_r   <= ADDR_WIDTH'(0);
            mem_cnt_r  <= CNT_WIDTH'(0);
            inflight_r <= 1'b0;
        end else begin
            if (push_fire_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (issue_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_fire_s, issue_s})
                2'b10:   mem_cnt_r <= mem_cnt_r + CNT_WIDTH'(1);
                2'b01:   mem_cnt_r <= mem_cnt_r - CNT_WIDTH'(1);
                default: mem_cnt_r <= mem_cnt_r;
            endcase
            // Macro data is valid only through the edge ending the cycle after issue.
            inflight_r <= issue_s;
        end
    end

    sram_fifo_outbuf u_outbuf (
        .clk      (clk),
        .rst      (rst),
        .capture  (inflight_r),
        .cap_data (sram_dout1),
        .pop      (bus.pop_ready),
        .head     (ob_head_s),
        .cnt      (ob_cnt_s)
    );

    a_no_same_addr: assert property (@(posedge clk) disable iff (rst)
        !(!sram_csb0 && !sram_csb1 && (sram_addr0 == sram_addr1)));

endmodule
